mem_arbiter: RTL

- Shares the single-port 4 KiB main memory between the CPU core and the GPU blitter.
- Accepts one level-held request per requester and serialises them onto the memory's primary read/write port.
- Routes read data and a one-cycle acknowledge back to the winning requester.
- Arbitration is GPU-priority with a CPU starvation guard; a read-response timeout prevents lock-up.

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port main memory between the CPU core and the GPU blitter.
// GPU has priority; a saturating CPU wait counter overrides it, and stuck reads time out.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned RD_TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              gpu_req,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [DATA_W-1:0] gpu_wdata,
    output logic [DATA_W-1:0] gpu_rdata,
    output logic              gpu_ack,

    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_read_ack,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,

    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StWr, StRdWait, StAck} state_t;

    state_t            state_q;
    logic              owner_gpu_q;
    logic [TMR_W-1:0]  rd_timer_q;
    logic [CNT_W-1:0]  cpu_wait_cnt_q;

    logic              grant_cpu;
    logic              grant_gpu;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Requests are only looked at in idle, so a req held through ACK is never served twice.
    always_comb begin
        grant_cpu = 1'b0;
        grant_gpu = 1'b0;
        if (state_q == StIdle) begin
            if (cpu_req && gpu_req) begin
                if (cpu_wait_cnt_q >= CNT_W'(STARVE_LIMIT)) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_gpu = 1'b1;
                end
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (gpu_req) begin
                grant_gpu = 1'b1;
            end
        end
    end

    assign sel_we    = grant_gpu ? gpu_we    : cpu_we;
    assign sel_addr  = grant_gpu ? gpu_addr  : cpu_addr;
    assign sel_wdata = grant_gpu ? gpu_wdata : cpu_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            owner_gpu_q    <= 1'b0;
            rd_timer_q     <= '0;
            cpu_wait_cnt_q <= '0;
            cpu_rdata      <= '0;
            cpu_ack        <= 1'b0;
            gpu_rdata      <= '0;
            gpu_ack        <= 1'b0;
            mem_read       <= 1'b0;
            mem_read_addr  <= '0;
            mem_write      <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            cpu_ack     <= 1'b0;
            gpu_ack     <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            err_timeout <= 1'b0;

            // Counts every cycle the CPU is kept waiting, busy cycles included.
            if (!cpu_req || grant_cpu) begin
                cpu_wait_cnt_q <= '0;
            end else if (cpu_wait_cnt_q < CNT_W'(STARVE_LIMIT)) begin
                cpu_wait_cnt_q <= cpu_wait_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_cpu || grant_gpu) begin
                        owner_gpu_q <= grant_gpu;
                        busy        <= 1'b1;
                        if (sel_we) begin
                            state_q        <= StWr;
                            mem_write      <= 1'b1;
                            mem_write_addr <= sel_addr;
                            mem_write_data <= sel_wdata;
                        end else begin
                            state_q       <= StRdWait;
                            mem_read      <= 1'b1;
                            mem_read_addr <= sel_addr;
                            rd_timer_q    <= '0;
                        end
                    end
                end
                StWr: begin
                    state_q <= StAck;
                    if (owner_gpu_q) gpu_ack <= 1'b1;
                    else             cpu_ack <= 1'b1;
                end
                StRdWait: begin
                    if (mem_read_ack) begin
                        state_q <= StAck;
                        if (owner_gpu_q) begin
                            gpu_ack   <= 1'b1;
                            gpu_rdata <= mem_read_data;
                        end else begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= mem_read_data;
                        end
                    end else if (rd_timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
                        // Memory never answered: complete with an all-ones error byte.
                        state_q     <= StAck;
                        err_timeout <= 1'b1;
                        if (owner_gpu_q) begin
                            gpu_ack   <= 1'b1;
                            gpu_rdata <= '1;
                        end else begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= '1;
                        end
                    end else begin
                        rd_timer_q <= rd_timer_q + TMR_W'(1);
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
